// File: rtl/dat_mem_pkg.sv
// Shared definitions for the data memory with hardware stack.
//   state_t : reload FSM states (INIT reloads the constant table, RUN is normal use)
//   TBL_LEN : number of words in the bit-mask / constant table
//   TBL     : table contents, reloaded at TBL_BASE after every reset
package dat_mem_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int TBL_LEN = 20;

  localparam logic [7:0] TBL [0:TBL_LEN-1] = '{
    8'h10, 8'hE0, 8'hF0, 8'hCC, 8'hAA, 8'd30, 8'h80, 8'd16, 8'd0,  8'hFF,
    8'h08, 8'h40, 8'hF8, 8'h01, 8'd8,  8'd60, 8'd15, 8'd33, 8'd34, 8'd35
  };

endpackage

// File: rtl/stk_ctrl.sv
// Descending-stack controller sharing the single RAM write port.
// Holds sp / count, derives full/empty from count, arbitrates push, pop,
// replace and plain stores, and keeps the sticky ovf/unf/col error flags.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_run               stack and store requests are honoured only when high
//   i_wr_en/i_addr/i_dat_in  plain store request
//   i_push/i_pop/i_stk_in    stack requests
//   i_err_clr           clears the sticky error flags
//   o_we/o_waddr/o_wdata     single RAM write request
//   o_sp                next free stack address
//   o_top_addr          address of the current top of stack (sp+1)
//   o_empty/o_full      stack count flags
//   o_ovf/o_unf/o_col   sticky overflow / underflow / write-collision
module stk_ctrl
  import dat_mem_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int SP_TOP   = 2**AW-1,
  parameter int SP_FLOOR = 2**AW-64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_run,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_dat_in,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_stk_in,
  input  logic          i_err_clr,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic [AW-1:0] o_sp,
  output logic [AW-1:0] o_top_addr,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_ovf,
  output logic          o_unf,
  output logic          o_col
);

  localparam int STK_DEPTH = SP_TOP - SP_FLOOR + 1;
  localparam int CNT_W     = $clog2(STK_DEPTH + 1);

  logic [AW-1:0]    r_sp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;
  logic             r_col;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_repl;
  logic w_do_pop;
  logic w_ovf_ev;
  logic w_unf_ev;
  logic w_col_ev;
  logic w_stk_we;
  logic [AW-1:0] w_top_addr;

  // Flags come from count so sp never needs a range compare.
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CNT_W'(STK_DEPTH));
  assign w_top_addr = r_sp + AW'(1);

  always_comb begin
    w_do_push = 1'b0;
    w_do_repl = 1'b0;
    w_do_pop  = 1'b0;
    w_ovf_ev  = 1'b0;
    w_unf_ev  = 1'b0;
    if (i_run) begin
      // push+pop on an empty stack degrades to a plain push
      w_do_push = i_push && (!i_pop || w_empty) && !w_full;
      w_do_repl = i_push && i_pop && !w_empty;
      w_do_pop  = i_pop && !i_push && !w_empty;
      // full implies non-empty, so a full push+pop is always a replace
      w_ovf_ev  = i_push && !i_pop && w_full;
      w_unf_ev  = i_pop && !i_push && w_empty;
    end
  end

  assign w_stk_we = w_do_push || w_do_repl;
  // A stack write owns the port; a coincident plain store is the loser.
  assign w_col_ev = i_run && i_wr_en && w_stk_we;

  always_comb begin
    o_we    = 1'b0;
    o_waddr = i_addr;
    o_wdata = i_dat_in;
    if (w_do_push) begin
      o_we    = 1'b1;
      o_waddr = r_sp;
      o_wdata = i_stk_in;
    end else if (w_do_repl) begin
      o_we    = 1'b1;
      o_waddr = w_top_addr;
      o_wdata = i_stk_in;
    end else if (i_run && i_wr_en) begin
      o_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= AW'(SP_TOP);
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_col <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_sp  <= r_sp - AW'(1);
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_do_pop) begin
        r_sp  <= r_sp + AW'(1);
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // a new error in the clearing cycle leaves the flag set
      r_ovf <= w_ovf_ev || (r_ovf && !i_err_clr);
      r_unf <= w_unf_ev || (r_unf && !i_err_clr);
      r_col <= w_col_ev || (r_col && !i_err_clr);
    end
  end

  assign o_sp       = r_sp;
  assign o_top_addr = w_top_addr;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_ovf      = r_ovf;
  assign o_unf      = r_unf;
  assign o_col      = r_col;

endmodule

// File: rtl/dat_mem_stk.sv
// Data memory with combinational read, automatic constant-table reload after
// reset, and a hardware descending stack sharing the single write port.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_en, addr, dat_in   plain store; dat_out = core[addr] (combinational)
//   push, pop, stk_in     stack operations; stk_top = core[sp+1]
//   sp                    next free stack address
//   stk_empty, stk_full   stack count flags
//   busy                  table reload in progress
//   err_clr               clears ovf/unf/col
//   ovf, unf, col         sticky overflow / underflow / write-collision
module dat_mem_stk
  import dat_mem_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int TBL_BASE = 60,
  parameter int SP_TOP   = 2**AW-1,
  parameter int SP_FLOOR = 2**AW-64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] stk_in,
  output logic [DW-1:0] stk_top,
  output logic [AW-1:0] sp,
  output logic          stk_empty,
  output logic          stk_full,
  output logic          busy,
  input  logic          err_clr,
  output logic          ovf,
  output logic          unf,
  output logic          col
);

  localparam int DEPTH = 2**AW;
  localparam int IDX_W = $clog2(TBL_LEN + 1);

  logic [DW-1:0] r_core [0:DEPTH-1];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;

  logic          w_tbl_we;
  logic [AW-1:0] w_tbl_addr;
  logic [DW-1:0] w_tbl_data;
  logic          w_run;

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [AW-1:0] w_top_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tbl_we    = 1'b0;
    case (r_state)
      INIT: begin
        w_tbl_we  = !reset;
        w_idx_nxt = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(TBL_LEN - 1)) begin
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = INIT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_tbl_addr = AW'(TBL_BASE) + AW'(r_idx);
  assign w_tbl_data = DW'(TBL[r_idx]);
  // While reloading, user writes and stack ops are ignored without flagging.
  assign w_run      = (r_state == RUN) && !reset;
  assign busy       = (r_state == INIT);

  stk_ctrl #(
    .DW       (DW),
    .AW       (AW),
    .SP_TOP   (SP_TOP),
    .SP_FLOOR (SP_FLOOR)
  ) u_stk_ctrl (
    .clk        (clk),
    .reset      (reset),
    .i_run      (w_run),
    .i_wr_en    (wr_en),
    .i_addr     (addr),
    .i_dat_in   (dat_in),
    .i_push     (push),
    .i_pop      (pop),
    .i_stk_in   (stk_in),
    .i_err_clr  (err_clr),
    .o_we       (w_we),
    .o_waddr    (w_waddr),
    .o_wdata    (w_wdata),
    .o_sp       (sp),
    .o_top_addr (w_top_addr),
    .o_empty    (stk_empty),
    .o_full     (stk_full),
    .o_ovf      (ovf),
    .o_unf      (unf),
    .o_col      (col)
  );

  // RAM contents are never reset; only the table window is rewritten.
  always_ff @(posedge clk) begin
    if (w_tbl_we) begin
      r_core[w_tbl_addr] <= w_tbl_data;
    end else if (w_we) begin
      r_core[w_waddr] <= w_wdata;
    end
  end

  assign dat_out = r_core[addr];
  assign stk_top = r_core[w_top_addr];

endmodule
